pes_uart_rx: RTL and testbench

UART receiver for 8N1 serial frames: the receiving end of the link clocked by the baud-rate generator. It runs on the 125 MHz system clock and derives its own 16x-oversample tick with the same `sel` rate encoding (115200/38400/19200/9600 bps). It recovers each byte from `rxd`, flags framing and overrun errors, and presents the byte on a valid/ready interface to the downstream consumer.

---
 rtl/pes_uart_rx_pkg.sv | 21 ++
 rtl/pes_uart_rx_if.sv | 20 ++
 rtl/pes_uart_rx_tick.sv | 47 ++++
 rtl/pes_uart_rx.sv | 155 +++++++++++++++
 tb/tb_pes_uart_rx.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pes_uart_rx_pkg.sv
// Shared UART definitions: default prescaler, sel-indexed rate multipliers and FSM states.
// The matching transmitter imports the same package.
package pes_uart_pkg;

    localparam int unsigned DIV_DEFAULT = 68;

    // Rate multiplier M per sel: 115200 / 38400 / 19200 / 9600 bps
    localparam logic [3:0] RATE_MULT [4] = '{4'd1, 4'd3, 4'd6, 4'd12};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_t;

    function automatic logic [3:0] rate_mult(input logic [1:0] sel);
        return RATE_MULT[sel];
    endfunction

endpackage

// File: rtl/pes_uart_rx_if.sv
// Received-byte valid/ready channel between the UART receiver and its consumer.
interface pes_uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/pes_uart_rx_tick.sv
// 16x oversample tick generator: prescaler, rate counter and a rate select latched per frame.
// clr restarts both counters so ticks are phase-aligned to the detected start edge.
module pes_uart_tick
    import pes_uart_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] sel,
    input  logic       clr,
    output logic       tick
);

    localparam int unsigned     PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] r_pre;
    logic [3:0]    r_rate;
    logic [1:0]    r_sel;
    logic [3:0]    w_rate_last;
    logic          w_pre_wrap;
    logic          w_rate_wrap;

    assign w_rate_last = rate_mult(r_sel) - 4'd1;
    assign w_pre_wrap  = (r_pre == PRE_LAST);
    assign w_rate_wrap = (r_rate == w_rate_last);
    assign tick        = w_pre_wrap & w_rate_wrap;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre  <= '0;
            r_rate <= '0;
            r_sel  <= '0;
        end else if (clr) begin
            r_pre  <= '0;
            r_rate <= '0;
            r_sel  <= sel;
        end else if (w_pre_wrap) begin
            r_pre  <= '0;
            r_rate <= w_rate_wrap ? '0 : r_rate + 4'd1;
        end else begin
            r_pre  <= r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/pes_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampling FSM, valid/ready output register
// with one-cycle framing and overrun error pulses.
module pes_uart_rx
    import pes_uart_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    sel,
    input  logic          rxd,
    pes_uart_rx_if.master rx,
    output logic          frame_err,
    output logic          overrun_err,
    output logic          busy
);

    logic        r_sync1;
    logic        r_rxs;
    logic        r_rxs_prev;
    uart_state_t r_state;
    logic [3:0]  r_tcnt;
    logic [2:0]  r_bidx;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx_data;
    logic        r_rx_valid;
    logic        r_frame_err;
    logic        r_overrun_err;
    logic        r_busy;
    logic        w_fall;
    logic        w_clr;
    logic        w_tick;

    assign w_fall = r_rxs_prev & ~r_rxs;
    assign w_clr  = (r_state == ST_IDLE) & w_fall;

    pes_uart_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .sel  (sel),
        .clr  (w_clr),
        .tick (w_tick)
    );

    // r_rxs_prev only feeds the falling-edge detector
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1    <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_rxs      <= r_sync1;
            r_rxs_prev <= r_rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_tcnt        <= '0;
            r_bidx        <= '0;
            r_shift       <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            if (r_rx_valid && rx.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_START;
                        r_tcnt  <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd7) begin
                            r_tcnt <= '0;
                            r_bidx <= '0;
                            if (!r_rxs) begin
                                r_state <= ST_DATA;
                            end else begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt  <= '0;
                            r_shift <= {r_rxs, r_shift[7:1]};
                            if (r_bidx == 3'd7) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_bidx <= r_bidx + 3'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end

                ST_STOP: begin
                    if (w_tick) begin
                        if (r_tcnt == 4'd15) begin
                            r_tcnt  <= '0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            // A consumer accepting on this same cycle frees the slot: load wins
                            if (!r_rxs) begin
                                r_frame_err <= 1'b1;
                            end else if (r_rx_valid && !rx.rx_ready) begin
                                r_overrun_err <= 1'b1;
                            end else begin
                                r_rx_data  <= r_shift;
                                r_rx_valid <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_data  = r_rx_data;
    assign rx.rx_valid = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pes_uart_rx.sv
// Directed bench for pes_uart_rx, run with a small prescaler so all four rates fit a short run.
module tb_pes_uart_rx;

    localparam int unsigned TB_DIV = 4;
    localparam int unsigned BIT0   = 16 * TB_DIV * 1;
    localparam int unsigned BIT1   = 16 * TB_DIV * 3;
    localparam int unsigned BIT2   = 16 * TB_DIV * 6;
    localparam int unsigned BIT3   = 16 * TB_DIV * 12;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       rxd = 1'b1;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    pes_uart_rx_if bus ();

    pes_uart_rx #(
        .DIV(TB_DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .rxd        (rxd),
        .rx         (bus),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned t_fall = 0;

    // Event monitor: byte loads (rx_valid rising), valid-high cycles, error pulse cycles
    int unsigned m_load_cnt = 0;
    int unsigned m_valid_hi = 0;
    int unsigned m_ferr = 0;
    int unsigned m_ovr = 0;
    int unsigned m_load_cyc = 0;
    int unsigned m_ferr_cyc = 0;
    int unsigned m_ovr_cyc = 0;
    logic [7:0]  m_load_data = '0;
    logic        m_prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1 && !m_prev_valid) begin
            m_load_cnt  <= m_load_cnt + 1;
            m_load_data <= bus.rx_data;
            m_load_cyc  <= cyc;
        end
        if (bus.rx_valid === 1'b1) m_valid_hi <= m_valid_hi + 1;
        if (frame_err === 1'b1) begin
            m_ferr     <= m_ferr + 1;
            m_ferr_cyc <= cyc;
        end
        if (overrun_err === 1'b1) begin
            m_ovr     <= m_ovr + 1;
            m_ovr_cyc <= cyc;
        end
        m_prev_valid <= (bus.rx_valid === 1'b1);
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; optionally flips sel to 00 at the start of data bit 3
    task automatic send_frame(input logic [7:0] b, input logic stopv,
                              input int unsigned bitclk, input logic tog);
        rxd    = 1'b0;
        t_fall = cyc;
        idle(bitclk);
        for (int i = 0; i < 8; i++) begin
            if (tog && i == 3) sel = 2'b00;
            rxd = b[i];
            idle(bitclk);
        end
        rxd = stopv;
        idle(bitclk);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        idle(4);
        vectors++;
        if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_out: valid=%b data=%h, want valid=0 data=00", bus.rx_valid, bus.rx_data);
        end
        vectors++;
        if ({busy, frame_err, overrun_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: busy/ferr/ovr=%b, want 000", {busy, frame_err, overrun_err});
        end
        reset = 1'b1;
        idle(4);
    endtask

    task automatic test_nominal;
        int unsigned l0, v0, f0, d;
        l0 = m_load_cnt; v0 = m_valid_hi; f0 = m_ferr;
        sel = 2'b00;
        bus.rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, BIT0, 1'b0);
        idle(8);
        vectors++;
        if (m_load_cnt - l0 !== 1 || m_load_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL nominal_data: loads=%0d data=%h, want 1 A5", m_load_cnt - l0, m_load_data);
        end
        vectors++;
        if (m_valid_hi - v0 !== 1) begin
            miscompares++;
            $display("FAIL nominal_valid_len: %0d cycles, want 1", m_valid_hi - v0);
        end
        d = m_load_cyc - t_fall;
        vectors++;
        if (d < 152 * TB_DIV || d > 152 * TB_DIV + 3) begin
            miscompares++;
            $display("FAIL nominal_latency: %0d clocks, want %0d..%0d", d, 152 * TB_DIV, 152 * TB_DIV + 3);
        end
        vectors++;
        if (busy !== 1'b0 || m_ferr - f0 !== 0) begin
            miscompares++;
            $display("FAIL nominal_idle: busy=%b ferr=%0d, want 0 0", busy, m_ferr - f0);
        end
    endtask

    task automatic test_all_rates;
        logic [1:0]  sels [3] = '{2'b01, 2'b10, 2'b11};
        int unsigned bits [3] = '{BIT1, BIT2, BIT3};
        int unsigned mult [3] = '{3, 6, 12};
        int unsigned l0, d;
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            l0 = m_load_cnt;
            sel = sels[i];
            send_frame(8'h3C, 1'b1, bits[i], 1'b0);
            idle(8);
            d = m_load_cyc - t_fall;
            vectors++;
            if (m_load_cnt - l0 !== 1 || m_load_data !== 8'h3C) begin
                miscompares++;
                $display("FAIL rate_data sel=%b: loads=%0d data=%h, want 1 3C", sels[i], m_load_cnt - l0, m_load_data);
            end
            vectors++;
            if (d < 152 * TB_DIV * mult[i] || d > 152 * TB_DIV * mult[i] + 3) begin
                miscompares++;
                $display("FAIL rate_latency sel=%b: %0d clocks, want %0d..+3", sels[i], d, 152 * TB_DIV * mult[i]);
            end
        end
        l0 = m_load_cnt;
        sel = 2'b01;
        send_frame(8'h3C, 1'b1, BIT1, 1'b1);
        idle(8);
        vectors++;
        if (m_load_cnt - l0 !== 1 || m_load_data !== 8'h3C) begin
            miscompares++;
            $display("FAIL rate_sel_toggle: loads=%0d data=%h, want 1 3C", m_load_cnt - l0, m_load_data);
        end
        sel = 2'b00;
    endtask

    task automatic test_glitch;
        int unsigned l0, f0;
        l0 = m_load_cnt; f0 = m_ferr;
        sel = 2'b00;
        rxd = 1'b0;
        idle(4 * TB_DIV);
        rxd = 1'b1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_detect: busy=%b, want 1", busy);
        end
        idle(8 * TB_DIV + 8);
        vectors++;
        if (busy !== 1'b0 || m_load_cnt - l0 !== 0 || m_ferr - f0 !== 0) begin
            miscompares++;
            $display("FAIL glitch_reject: busy=%b loads=%0d ferr=%0d, want 0 0 0", busy, m_load_cnt - l0, m_ferr - f0);
        end
    endtask

    task automatic test_framing;
        int unsigned l0, f0, d;
        l0 = m_load_cnt; f0 = m_ferr;
        sel = 2'b00;
        bus.rx_ready = 1'b1;
        send_frame(8'h55, 1'b0, BIT0, 1'b0);
        idle(16);
        d = m_ferr_cyc - t_fall;
        vectors++;
        if (m_ferr - f0 !== 1 || m_load_cnt - l0 !== 0 || bus.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL framing_err: ferr=%0d loads=%0d valid=%b, want 1 0 0", m_ferr - f0, m_load_cnt - l0, bus.rx_valid);
        end
        vectors++;
        if (d < 152 * TB_DIV || d > 152 * TB_DIV + 3) begin
            miscompares++;
            $display("FAIL framing_time: %0d clocks, want %0d..+3", d, 152 * TB_DIV);
        end
        l0 = m_load_cnt;
        send_frame(8'h0F, 1'b1, BIT0, 1'b0);
        idle(8);
        vectors++;
        if (m_load_cnt - l0 !== 1 || m_load_data !== 8'h0F) begin
            miscompares++;
            $display("FAIL framing_recover: loads=%0d data=%h, want 1 0F", m_load_cnt - l0, m_load_data);
        end
    endtask

    task automatic test_back_to_back;
        int unsigned l0, o0, d;
        l0 = m_load_cnt; o0 = m_ovr;
        sel = 2'b00;
        bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, BIT0, 1'b0);
        send_frame(8'h22, 1'b1, BIT0, 1'b0);
        idle(8);
        d = m_ovr_cyc - t_fall;
        vectors++;
        if (m_load_cnt - l0 !== 1 || bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h11) begin
            miscompares++;
            $display("FAIL overrun_hold: loads=%0d valid=%b data=%h, want 1 1 11", m_load_cnt - l0, bus.rx_valid, bus.rx_data);
        end
        vectors++;
        if (m_ovr - o0 !== 1) begin
            miscompares++;
            $display("FAIL overrun_pulse: %0d pulses, want 1", m_ovr - o0);
        end
        vectors++;
        if (d < 152 * TB_DIV || d > 152 * TB_DIV + 3) begin
            miscompares++;
            $display("FAIL overrun_time: %0d clocks, want %0d..+3", d, 152 * TB_DIV);
        end
        bus.rx_ready = 1'b1;
        idle(1);
        vectors++;
        if (bus.rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: valid=%b, want 0", bus.rx_valid);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0]  b;
        int unsigned l0, f0, o0;
        b = 8'h96;
        sel = 2'b00;
        bus.rx_ready = 1'b1;
        l0 = m_load_cnt; f0 = m_ferr; o0 = m_ovr;
        rxd = 1'b0;
        idle(BIT0);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            idle(BIT0);
        end
        rxd = b[4];
        idle(BIT0 / 2);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        vectors++;
        if ({busy, bus.rx_valid, frame_err, overrun_err} !== 4'b0000 || bus.rx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_out: busy/valid/ferr/ovr=%b data=%h, want 0000 00",
                     {busy, bus.rx_valid, frame_err, overrun_err}, bus.rx_data);
        end
        rxd = 1'b1;
        idle(2 * BIT0);
        vectors++;
        if (busy !== 1'b0 || m_load_cnt - l0 !== 0 || m_ferr - f0 !== 0 || m_ovr - o0 !== 0) begin
            miscompares++;
            $display("FAIL midreset_quiet: busy=%b loads=%0d ferr=%0d ovr=%0d, want all 0",
                     busy, m_load_cnt - l0, m_ferr - f0, m_ovr - o0);
        end
        send_frame(8'hC3, 1'b1, BIT0, 1'b0);
        idle(8);
        vectors++;
        if (m_load_cnt - l0 !== 1 || m_load_data !== 8'hC3) begin
            miscompares++;
            $display("FAIL midreset_next: loads=%0d data=%h, want 1 C3", m_load_cnt - l0, m_load_data);
        end
    endtask

    initial begin
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset;
        test_nominal;
        test_all_rates;
        test_glitch;
        test_framing;
        test_back_to_back;
        test_reset_mid_frame;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
